// File: rtl/rr_merge_2x1.sv
// Two-input round-robin stream merge. Each cycle the winning source is
// registered into a single-entry output buffer. Ties go to the favoured
// source, and whichever source is served hands the favour to the other.
module rr_merge_2x1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,

    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,

    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned DW = WIDTH;

    // Output buffer and round-robin priority state
    logic [DW-1:0] r_out_data;
    logic          r_out_src;
    logic          r_out_valid;
    logic          r_pri;

    // Next-state values
    logic [DW-1:0] w_out_data_nxt;
    logic          w_out_src_nxt;
    logic          w_out_valid_nxt;
    logic          w_pri_nxt;

    // Handshake decode
    logic          w_load_en;
    logic          w_grant;
    logic          w_take0;
    logic          w_take1;

    // Buffer may load when empty or draining this cycle; grant picks the
    // lone valid source, or the favoured one under contention.
    always_comb begin
        w_load_en = 1'b0;
        w_grant   = 1'b0;
        w_take0   = 1'b0;
        w_take1   = 1'b0;

        // Reset discards any concurrent transfer, so no handshake completes.
        w_load_en = !rst && (!r_out_valid || out_ready);

        if (in0_valid && in1_valid) begin
            w_grant = r_pri;
        end else if (in1_valid) begin
            w_grant = 1'b1;
        end else begin
            w_grant = 1'b0;
        end

        w_take0 = w_load_en && in0_valid && (w_grant == 1'b0);
        w_take1 = w_load_en && in1_valid && (w_grant == 1'b1);
    end

    // Next-state for the output buffer and priority
    always_comb begin
        w_out_data_nxt  = r_out_data;
        w_out_src_nxt   = r_out_src;
        w_out_valid_nxt = r_out_valid;
        w_pri_nxt       = r_pri;

        if (w_take0) begin
            w_out_data_nxt  = in0_data;
            w_out_src_nxt   = 1'b0;
            w_out_valid_nxt = 1'b1;
            w_pri_nxt       = 1'b1;
        end else if (w_take1) begin
            w_out_data_nxt  = in1_data;
            w_out_src_nxt   = 1'b1;
            w_out_valid_nxt = 1'b1;
            w_pri_nxt       = 1'b0;
        end else if (r_out_valid && out_ready) begin
            // Drain only; data and source keep their last values.
            w_out_valid_nxt = 1'b0;
        end
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_src   <= 1'b0;
            r_out_valid <= 1'b0;
            r_pri       <= 1'b0;
        end else begin
            r_out_data  <= w_out_data_nxt;
            r_out_src   <= w_out_src_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_pri       <= w_pri_nxt;
        end
    end

    assign in0_ready = w_take0;
    assign in1_ready = w_take1;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_valid = r_out_valid;

    // Handshake sanity: one winner at most, never a ready without valid,
    // and a stalled buffer stays put.
    a_one_ready: assert property (@(posedge clk) !(in0_ready && in1_ready));
    a_rdy0_vld:  assert property (@(posedge clk) in0_ready |-> in0_valid);
    a_rdy1_vld:  assert property (@(posedge clk) in1_ready |-> in1_valid);
    a_stall_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_src)));

endmodule

// File: doc/rr_merge_2x1.md
Name: rr_merge_2x1

Overview:
Two-input round-robin stream merge with valid/ready handshakes on both inputs and on the output. It is the sequential control stage that owns the 2:1 select. Each cycle it decides which source passes and registers the chosen word into a single-entry output buffer. It sits between two independent producers and one consumer, and fairly interleaves them under contention.

Parameters:
WIDTH, 8, data width of each input stream and of the output stream.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  reset, synchronous and active-high.
in0_data  input  WIDTH  source 0 payload.
in0_valid  input  1  source 0 has a word.
in0_ready  output  1  source 0 word accepted this cycle (when in0_valid is also high).
in1_data  input  WIDTH  source 1 payload.
in1_valid  input  1  source 1 has a word.
in1_ready  output  1  source 1 word accepted this cycle (when in1_valid is also high).
out_data  output  WIDTH  registered merged payload.
out_src  output  1  source index of the word in out_data.
out_valid  output  1  out_data/out_src hold a word.
out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset:
  - rst is synchronous and active-high. When rst is high at a rising clk edge, the next state is out_valid=0, out_data=0, out_src=0, pri=0 (source 0 favoured).
  - Reset overrides any concurrent transfer. A word held in the buffer mid-operation is discarded.
- Internal state:
  - out buffer: out_data, out_src, out_valid.
  - pri: 1 bit, the favoured source on a tie.
- Load enable: load_en = !out_valid || out_ready. This is combinational and allows a drain and a load in the same cycle.
- Grant (combinational):
  - Only in0_valid high: grant = 0.
  - Only in1_valid high: grant = 1.
  - Both high: grant = pri.
  - Neither high: no grant.
- Ready outputs:
  - inX_ready = load_en && inX_valid && (grant == X).
  - At most one ready is high per cycle. Ready is never high for a non-valid input.
  - Ready may depend combinationally on valid and on out_ready. Sources must not make valid depend on ready.
- On a clk edge with a transfer from source X:
  - out_data <= inX_data, out_src <= X, out_valid <= 1.
  - pri <= !X. The source just served loses priority, whether or not there was contention.
- On a clk edge with no input transfer and out_valid && out_ready: out_valid <= 0. out_data and out_src hold their last values.
- Backpressure: while out_valid && !out_ready, out_data, out_src and out_valid hold stable, and both in*_ready are 0.
- Latency and throughput:
  - 1 cycle from input handshake to out_valid.
  - Sustained rate is 1 word per cycle when out_ready is held high.
  - Under continuous contention the outputs alternate 0,1,0,1… starting from pri.
- No word is lost or duplicated. Every input handshake produces exactly one output handshake, in grant order.
- Starvation bound: a continuously valid source is served within 2 transfers.
- Single clock domain. No combinational path from in*_data to out_data.

Test Plan:
- Reset values: assert rst for 2 cycles with all inputs random -> out_valid=0, out_data=0, out_src=0, in0_ready=in1_ready=0. First contended grant after reset goes to source 0.
- Single source: in0_valid=1, in0_data=0x11, then 0x22, 0x33 on consecutive cycles, out_ready=1 -> out_data 0x11, 0x22, 0x33 on cycles 1, 2, 3, all with out_src=0. in1_ready stays 0 throughout.
- Contention fairness: both valid continuously (in0_data=0xA0+n, in1_data=0xB0+n), out_ready=1 -> output sequence A0, B0, A1, B1, … with out_src toggling 0, 1, 0, 1.
- Backpressure: buffer holds 0x5A with out_ready=0 for 4 cycles -> out_data=0x5A stable, out_valid=1, both readys 0. Raising out_ready drains 0x5A and loads the next granted word in the same cycle.
- Priority update without contention: in1 alone sends 0x77, then both valid -> next grant goes to source 0.
- Reset mid-operation: out_valid=1 holding 0x3C, both sources valid, rst pulsed 1 cycle -> out_valid=0 the next cycle, 0x3C never handshaken, pri=0. Traffic resumes with source 0 on the cycle after rst falls.
- Scoreboard all runs with 200+ random cycles of valid and out_ready: output words are exactly the accepted inputs, in accept order, with correct out_src.
